// File: rtl/avg_window_filter_pkg.sv
// avg_window_filter_pkg: shared FSM encoding, handshake levels and alarm helper
package avg_window_filter_pkg;
  typedef enum logic [2:0] {
    S_IN,
    S_INACK,
    S_CALC,
    S_OUT,
    S_OUTACK
  } state_t;
  localparam logic DAV_ASSERT = 1'b0;
  localparam logic RFD_READY = 1'b1;
  function automatic logic alarm_next(input logic [7:0] m, input logic prev, input logic [7:0] hi, input logic [7:0] lo);
    return (m >= hi) ? 1'b1 : (m <= lo) ? 1'b0 : prev;
  endfunction
endpackage

// File: rtl/avg_window_filter_window_ring.sv
// window_ring: circular buffer of the last 2**LOG2_DEPTH samples with a running sum
module window_ring
  import avg_window_filter_pkg::*;
#(
  parameter int LOG2_DEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  prime,
  input  logic [7:0]            x,
  output logic [7+LOG2_DEPTH:0] sum
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW = 8 + LOG2_DEPTH;
  logic [7:0] win [DEPTH];
  logic [LOG2_DEPTH-1:0] wp;
  // Priming fills every entry with the first sample so the first mean equals it;
  // afterwards the oldest entry is swapped out of the sum and overwritten.
  always_ff @(posedge clock) begin
    if (reset) begin
      wp <= '0;
      sum <= '0;
      for (int i = 0; i < DEPTH; i++) win[i] <= '0;
    end else if (load) begin
      if (prime) begin
        for (int i = 0; i < DEPTH; i++) win[i] <= x;
        sum <= {x, {LOG2_DEPTH{1'b0}}};
        wp <= LOG2_DEPTH'(1);
      end else begin
        sum <= sum - SW'(win[wp]) + SW'(x);
        win[wp] <= x;
        wp <= wp + LOG2_DEPTH'(1);
      end
    end
  end
endmodule

// File: rtl/avg_window_filter.sv
// avg_window_filter: sliding-window mean of upstream averages with hysteresis alarm
module avg_window_filter
  import avg_window_filter_pkg::*;
#(
  parameter int         LOG2_DEPTH = 2,
  parameter logic [7:0] TH_HI      = 8'd100,
  parameter logic [7:0] TH_LO      = 8'd80
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dav_in_,
  input  logic [7:0] avg_in,
  output logic       rfd_in,
  output logic       dav_out_,
  input  logic       rfd_out,
  output logic [7:0] mean,
  output logic       alarm
);
  state_t state;
  logic [7:0] x;
  logic primed;
  logic load;
  logic [7+LOG2_DEPTH:0] sum;
  logic [7:0] new_mean;
  // The ring is written as upstream releases dav_in_, so its sum is settled
  // during S_CALC and the mean can be registered on that cycle.
  assign load = (state == S_INACK) && (dav_in_ != DAV_ASSERT);
  assign new_mean = sum[LOG2_DEPTH +: 8];
  window_ring #(.LOG2_DEPTH(LOG2_DEPTH)) u_ring (
    .clock(clock),
    .reset(reset),
    .load (load),
    .prime(~primed),
    .x    (x),
    .sum  (sum)
  );
  // Handshake FSM with registered rfd_in/dav_out_ and mean/alarm held between outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IN;
      rfd_in <= RFD_READY;
      dav_out_ <= ~DAV_ASSERT;
      mean <= '0;
      alarm <= 1'b0;
      primed <= 1'b0;
      x <= '0;
    end else begin
      case (state)
        S_IN:
          if (dav_in_ == DAV_ASSERT) begin
            x <= avg_in;
            rfd_in <= ~RFD_READY;
            state <= S_INACK;
          end
        S_INACK:
          if (dav_in_ != DAV_ASSERT) begin
            primed <= 1'b1;
            state <= S_CALC;
          end
        S_CALC: begin
          mean <= new_mean;
          alarm <= alarm_next(new_mean, alarm, TH_HI, TH_LO);
          state <= S_OUT;
        end
        S_OUT:
          if (rfd_out == RFD_READY) begin
            dav_out_ <= DAV_ASSERT;
            state <= S_OUTACK;
          end
        S_OUTACK:
          if (rfd_out != RFD_READY) begin
            dav_out_ <= ~DAV_ASSERT;
            rfd_in <= RFD_READY;
            state <= S_IN;
          end
        default: state <= S_IN;
      endcase
    end
  end
endmodule
